wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of FIFO entries (power of 2, min 2).
REQ-002 SHALL have parameter STAMP_W, default 16, meaning width of the cycle timestamp.
REQ-003 SHALL use one clock; reset is asynchronous and active-low, with ports named clk and reset as in the rest of the CPU.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 wb_we  input  1  CPU writeback stage is writing the register file this cycle.
REQ-007 wb_reg  input  5  writeback destination register number (CPU RegisterNo).
REQ-008 wb_data  input  32  writeback data (CPU RegisterContent).
REQ-009 clear  input  1  synchronous flush of buffer and sticky flags.
REQ-010 out_valid  output  1  head entry is available.
REQ-011 out_ready  input  1  consumer accepts the head entry.
REQ-012 out_reg  output  5  head entry register number.
REQ-013 out_data  output  32  head entry data.
REQ-014 out_stamp  output  STAMP_W  head entry capture timestamp.
REQ-015 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 overflow  output  1  sticky: at least one capture dropped because the buffer was full.

Function
REQ-017 SHALL keep a free-running STAMP_W-bit cycle counter, +1 every clk, wrapping from all-ones to 0; clear does not affect it.
REQ-018 A capture SHALL be requested when wb_we=1 and wb_reg!=0; writes to $0 are ignored.
REQ-019 Captured entry SHALL be {wb_reg, wb_data, stamp value in the capture cycle}.
REQ-020 Pop SHALL occur when out_valid=1 and out_ready=1 in the same cycle; the head advances at that edge.
REQ-021 Push SHALL be accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
REQ-022 Push when full with no pop SHALL drop the entry, set overflow=1, and leave count unchanged.
REQ-023 Simultaneous push and pop SHALL leave count unchanged.
REQ-024 Push into an empty buffer SHALL produce out_valid=1 on the following cycle (1-cycle latency); no same-cycle bypass.
REQ-025 out_reg/out_data/out_stamp SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 out_valid SHALL equal (count!=0).
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 clear=1 SHALL at the next edge set count=0 and overflow=0 and reset both pointers, with priority over push and pop in that cycle; the capture in that cycle is discarded.
REQ-029 overflow SHALL clear only by clear or reset.
REQ-030 out_* data outputs SHALL be don't-care when out_valid=0; the bench does not check them.

Reset
REQ-031 reset=0 SHALL asynchronously force count=0, out_valid=0, overflow=0, pointers=0, and stamp=0.
REQ-032 Storage contents SHALL NOT need a reset.
REQ-033 An in-progress push or pop at reset assertion SHALL be lost; the first post-reset entry lands at index 0.
REQ-034 On the first rising edge after reset deasserts, the stamp SHALL advance from 0 to 1.

Verification
REQ-035 Reset deassert, then wb_we=1, wb_reg=5, wb_data=0xDEADBEEF at stamp 3 with out_ready=0 -> next cycle: out_valid=1, out_reg=5, out_data=0xDEADBEEF, out_stamp=3, count=1.
REQ-036 wb_we=1, wb_reg=0, wb_data=0x1234 -> count stays 0 and out_valid stays 0.
REQ-037 With out_ready=0, push 9 entries reg 1..9 -> count=8, overflow=1; drain -> regs 1..8 in order, then out_valid=0.
REQ-038 Buffer full, then push reg 10 with out_ready=1 in the same cycle -> count stays 8, no overflow, and reg 10 becomes the last entry out.
REQ-039 count=3, overflow=1, then clear=1 together with a push -> next cycle count=0, overflow=0, out_valid=0.
REQ-040 reset pulsed low mid-drain with count=5 -> count=0 and out_valid=0 immediately, without waiting for clk; stamp restarts from 0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: timestamped FIFO capture of CPU register-file writebacks.
// Each non-$0 writeback is stored as {reg, data, stamp}. When the buffer is full
// and nothing is popped, the capture is dropped and a sticky overflow flag is set.
module wb_trace_buffer #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_we,
  input  logic [4:0]               wb_reg,
  input  logic [31:0]              wb_data,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_reg,
  output logic [31:0]              out_data,
  output logic [STAMP_W-1:0]       out_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [STAMP_W-1:0] r_stamp;
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;

  logic [4:0]         r_mem_reg   [DEPTH];
  logic [31:0]        r_mem_data  [DEPTH];
  logic [STAMP_W-1:0] r_mem_stamp [DEPTH];

  logic w_req;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A full buffer still accepts a push when the head is popped at the same edge.
  assign w_req  = wb_we && (wb_reg != 5'd0);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = out_valid && out_ready && !clear;
  assign w_push = w_req && !clear && (!w_full || w_pop);
  assign w_drop = w_req && !clear && w_full && !w_pop;

  // Free-running capture timestamp; unaffected by clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
    end
  end

  // Pointers, occupancy and sticky overflow; clear outranks push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wptr]   <= wb_reg;
      r_mem_data[r_wptr]  <= wb_data;
      r_mem_stamp[r_wptr] <= r_stamp;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_reg   = r_mem_reg[r_rptr];
  assign out_data  = r_mem_data[r_rptr];
  assign out_stamp = r_mem_stamp[r_rptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed sequences, a table of
// hand-derived vectors, and randomized traffic against a queue-based model.
module tb_wb_trace_buffer;

  localparam int DEPTH   = 8;
  localparam int STAMP_W = 16;

  logic                   clk;
  logic                   reset;
  logic                   wb_we;
  logic [4:0]             wb_reg;
  logic [31:0]            wb_data;
  logic                   clear;
  logic                   out_valid;
  logic                   out_ready;
  logic [4:0]             out_reg;
  logic [31:0]            out_data;
  logic [STAMP_W-1:0]     out_stamp;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  int n_checks = 0;
  int n_fail   = 0;

  wb_trace_buffer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_we     (wb_we),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_reg   (out_reg),
    .out_data  (out_data),
    .out_stamp (out_stamp),
    .count     (count),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an ordered queue of captured entries plus a cycle counter.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int unsigned s;
  } ent_t;

  ent_t        mq[$];
  bit          m_ovf   = 1'b0;
  int unsigned m_stamp = 0;

  typedef struct {
    bit       we;
    bit [4:0] rg;
    bit       rdy;
    bit       clr;
    int       cnt;
    bit       ovf;
    int       head;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_stamp = 0;
  endtask

  task automatic model_edge();
    bit   pop;
    bit   req;
    ent_t e;
    if (clear) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (mq.size() != 0) && out_ready;
      req = wb_we && (wb_reg != 5'd0);
      if (pop) mq.delete(0);
      if (req) begin
        if (mq.size() < DEPTH) begin
          e.r = wb_reg;
          e.d = wb_data;
          e.s = m_stamp;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_stamp = (m_stamp + 1) % (1 << STAMP_W);
  endtask

  task automatic model_check();
    chk("m_count", 64'(count), 64'(mq.size()));
    chk("m_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("m_overflow", 64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("m_reg", 64'(out_reg), 64'(mq[0].r));
      chk("m_data", 64'(out_data), 64'(mq[0].d));
      chk("m_stamp", 64'(out_stamp), 64'(mq[0].s));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic drive(input bit we, input logic [4:0] rg, input logic [31:0] d,
                       input bit rdy, input bit clr);
    wb_we     = we;
    wb_reg    = rg;
    wb_data   = d;
    out_ready = rdy;
    clear     = clr;
  endtask

  function automatic void add(input bit we, input int rg, input bit rdy, input bit clr,
                              input int cnt, input bit ovf, input int head);
    vec_t v;
    v.we   = we;
    v.rg   = 5'(rg);
    v.rdy  = rdy;
    v.clr  = clr;
    v.cnt  = cnt;
    v.ovf  = ovf;
    v.head = head;
    tbl.push_back(v);
  endfunction

  int bias;

  initial begin
    // Table of vectors; head 0 means the buffer is expected empty.
    for (int i = 1; i <= 9; i++) add(1, i, 0, 0, (i < 8) ? i : 8, i == 9, 1);
    for (int i = 1; i <= 8; i++) add(0, 0, 1, 0, 8 - i, 1, (i < 8) ? i + 1 : 0);
    add(0, 0, 0, 1, 0, 0, 0);
    for (int i = 11; i <= 18; i++) add(1, i, 0, 0, i - 10, 0, 11);
    add(1, 10, 1, 0, 8, 0, 12);
    for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 8 - k, 0, (k == 8) ? 0 : (k == 7) ? 10 : 12 + k);
    for (int i = 1; i <= 9; i++) add(1, i, 0, 0, (i < 8) ? i : 8, i == 9, 1);
    for (int k = 1; k <= 5; k++) add(0, 0, 1, 0, 8 - k, 1, k + 1);
    add(1, 7, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    drive(0, 5'd0, 32'd0, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    #6 reset = 1'b1;

    // Three idle edges bring the stamp to 3, then capture reg 5.
    for (int i = 0; i < 3; i++) step();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0);
    step();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_reg", 64'(out_reg), 64'd5);
    chk("first_data", 64'(out_data), 64'hDEADBEEF);
    chk("first_stamp", 64'(out_stamp), 64'd3);
    chk("first_count", 64'(count), 64'd1);

    drive(0, 5'd0, 32'd0, 1, 0);
    step();
    drive(1, 5'd0, 32'h1234, 0, 0);
    step();
    chk("reg0_count", 64'(count), 64'd0);
    chk("reg0_valid", 64'(out_valid), 64'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].rg, {24'hC0FFEE, 3'b0, tbl[i].rg}, tbl[i].rdy, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].cnt != 0));
      if (tbl[i].head != 0) chk($sformatf("tbl%0d_head", i), 64'(out_reg), 64'(tbl[i].head));
    end

    // Asynchronous reset in the middle of a drain with five entries held.
    for (int i = 1; i <= 7; i++) begin
      drive(1, 5'(i), 32'(i * 3), 0, 0);
      step();
    end
    drive(0, 5'd0, 32'd0, 1, 0);
    step();
    step();
    chk("pre_rst_count", 64'(count), 64'd5);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    #2 reset = 1'b1;
    drive(1, 5'd4, 32'h0000_0044, 0, 0);
    step();
    chk("post_rst_stamp", 64'(out_stamp), 64'd0);
    chk("post_rst_reg", 64'(out_reg), 64'd4);
    chk("post_rst_count", 64'(count), 64'd1);

    // Randomized traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = $urandom_range(10, 95);
      drive(($urandom % 4) != 0, 5'($urandom % 32), $urandom,
            ($urandom % 100) < bias, ($urandom % 150) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
